// File: rtl/nap_pkg.sv
// nap_pkg: shared types and constants for the nap countdown controller.
//   state_e      FSM state encoding as seen on state_o
//   SEC_W/MIN_W  widths of the seconds and minutes registers
//   min_to_sec() converts a minute count to seconds in SEC_W bits
package nap_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_PAUSE  = 3'd2,
    S_RING   = 3'd3,
    S_SNOOZE = 3'd4
  } state_e;

  localparam int SEC_W       = 13;
  localparam int MIN_W       = 7;
  localparam int SEC_PER_MIN = 60;

  // 13 bits hold up to 8191 s, so any minute count <= 136 converts without overflow.
  function automatic logic [SEC_W-1:0] min_to_sec(input logic [MIN_W-1:0] m);
    logic [SEC_W-1:0] s;
    s = SEC_W'(m) * SEC_W'(SEC_PER_MIN);
    return s;
  endfunction

endpackage

// File: rtl/nap_timer_sec_prescaler.sv
// sec_prescaler: divides the system clock down to a one-cycle second tick.
//   clock     in   system clock
//   reset     in   asynchronous, active-low
//   clr       in   restart the second from zero (wins over en)
//   en        in   advance the count this cycle
//   sec_tick  out  high in the last cycle of each second while enabled
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic sec_tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sec_tick = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/nap_timer.sv
// nap_timer: nap countdown controller feeding the alarm light sequencer.
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-low
//   btn_up     in   debounced level, raise nap length (IDLE only)
//   btn_down   in   debounced level, lower nap length (IDLE only)
//   btn_go     in   debounced level, start / pause / resume / snooze
//   btn_stop   in   debounced level, cancel or silence
//   set_min    out  programmed nap length in minutes
//   remaining  out  seconds left in the current countdown
//   state_o    out  FSM state (nap_pkg::state_e encoding)
//   start      out  one-cycle pulse on entry to RING
//   stop       out  low only while in RING
// MAX_MIN must not exceed 136 so that set_min*60 fits in 13 bits.
module nap_timer
  import nap_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int DEF_MIN       = 20,
  parameter int MAX_MIN       = 90,
  parameter int SNOOZE_SEC    = 300,
  parameter int MAX_SNOOZE    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_go,
  input  logic             btn_stop,
  output logic [MIN_W-1:0] set_min,
  output logic [SEC_W-1:0] remaining,
  output logic [2:0]       state_o,
  output logic             start,
  output logic             stop
);

  localparam int SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  // Button index into the edge-detect vector.
  localparam int B_UP   = 0;
  localparam int B_DOWN = 1;
  localparam int B_GO   = 2;
  localparam int B_STOP = 3;

  state_e           state_q, state_d;
  logic [MIN_W-1:0] set_min_q, set_min_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic [SNZ_W-1:0] snz_q, snz_d;
  logic [3:0]       btn_q, btn_now, btn_ev;
  logic             start_q, stop_q;

  logic             pre_clr, pre_en, sec_tick;
  logic             ev_up, ev_down, ev_go, ev_stop;
  logic             counting;

  // Rising-edge events; a held button yields exactly one event.
  assign btn_now = {btn_stop, btn_go, btn_down, btn_up};
  assign btn_ev  = btn_now & ~btn_q;
  assign ev_up   = btn_ev[B_UP];
  assign ev_down = btn_ev[B_DOWN];
  assign ev_go   = btn_ev[B_GO];
  assign ev_stop = btn_ev[B_STOP];

  assign counting = (state_q == S_COUNT) || (state_q == S_SNOOZE);
  assign pre_en   = counting;

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_presc (
    .clock   (clock),
    .reset   (reset),
    .clr     (pre_clr),
    .en      (pre_en),
    .sec_tick(sec_tick)
  );

  always_comb begin
    state_d   = state_q;
    set_min_d = set_min_q;
    rem_d     = rem_q;
    snz_d     = snz_q;
    pre_clr   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ev_stop) begin
          // Nothing to cancel; stop still masks go/up/down this cycle.
        end else if (ev_go) begin
          rem_d   = min_to_sec(set_min_q);
          snz_d   = '0;
          pre_clr = 1'b1;
          state_d = S_COUNT;
        end else if (ev_up && !ev_down) begin
          if (set_min_q != MIN_W'(MAX_MIN))
            set_min_d = set_min_q + MIN_W'(1);
        end else if (ev_down && !ev_up) begin
          if (set_min_q > MIN_W'(1))
            set_min_d = set_min_q - MIN_W'(1);
        end
      end

      S_COUNT, S_SNOOZE: begin
        if (ev_stop) begin
          // Cancel wins even over an expiring tick: no ring.
          rem_d   = '0;
          state_d = S_IDLE;
        end else if (sec_tick && rem_q <= SEC_W'(1)) begin
          // Expiry beats a same-cycle pause so the nap never parks at zero.
          rem_d   = '0;
          state_d = S_RING;
        end else begin
          // The tick already consumed its second, so keep it even when pausing.
          if (sec_tick)
            rem_d = rem_q - SEC_W'(1);
          if (ev_go && state_q == S_COUNT)
            state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (ev_stop) begin
          rem_d   = '0;
          state_d = S_IDLE;
        end else if (ev_go) begin
          // Resume keeps the partial second held in the prescaler.
          state_d = S_COUNT;
        end
      end

      S_RING: begin
        if (ev_stop) begin
          state_d = S_IDLE;
        end else if (ev_go && snz_q < SNZ_W'(MAX_SNOOZE)) begin
          snz_d   = snz_q + SNZ_W'(1);
          rem_d   = SEC_W'(SNOOZE_SEC);
          pre_clr = 1'b1;
          state_d = S_SNOOZE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      set_min_q <= MIN_W'(DEF_MIN);
      rem_q     <= '0;
      snz_q     <= '0;
      btn_q     <= '0;
      start_q   <= 1'b0;
      stop_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      set_min_q <= set_min_d;
      rem_q     <= rem_d;
      snz_q     <= snz_d;
      btn_q     <= btn_now;
      // Both taken from the next state so they line up with state_o.
      start_q   <= (state_d == S_RING) && (state_q != S_RING);
      stop_q    <= (state_d != S_RING);
    end
  end

  assign set_min   = set_min_q;
  assign remaining = rem_q;
  assign state_o   = state_q;
  assign start     = start_q;
  assign stop      = stop_q;

endmodule

// File: tb/tb_nap_timer.sv
module tb_nap_timer;

  logic        clock;
  logic        reset;
  logic        btn_up, btn_down, btn_go, btn_stop;
  logic [6:0]  set_min;
  logic [12:0] remaining;
  logic [2:0]  state_o;
  logic        start, stop;

  int errors = 0;
  int checks = 0;

  nap_timer #(
    .TICKS_PER_SEC(4),
    .DEF_MIN      (1),
    .MAX_MIN      (90),
    .SNOOZE_SEC   (2),
    .MAX_SNOOZE   (1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_go   (btn_go),
    .btn_stop (btn_stop),
    .set_min  (set_min),
    .remaining(remaining),
    .state_o  (state_o),
    .start    (start),
    .stop     (stop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // which: 0=up 1=down 2=go 3=stop; each press is one high cycle then one low cycle.
  task automatic press(input int which, input int n);
    repeat (n) begin
      case (which)
        0: btn_up   = 1'b1;
        1: btn_down = 1'b1;
        2: btn_go   = 1'b1;
        default: btn_stop = 1'b1;
      endcase
      step();
      btn_up = 1'b0; btn_down = 1'b0; btn_go = 1'b0; btn_stop = 1'b0;
      step();
    end
  endtask

  initial begin
    btn_up = 0; btn_down = 0; btn_go = 0; btn_stop = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_state",   state_o,   0);
    chk("rst_set_min", set_min,   1);
    chk("rst_remain",  remaining, 0);
    chk("rst_start",   start,     0);
    chk("rst_stop",    stop,      1);
    #9 reset = 1'b1;
    step();

    // Nap length programming with saturation at both ends.
    press(0, 2);   chk("up2",     set_min, 3);
    press(1, 5);   chk("down5",   set_min, 1);
    press(0, 200); chk("up200",   set_min, 90);
    chk("idle_remain", remaining, 0);
    chk("idle_stop",   stop,      1);
    press(1, 89);  chk("down89",  set_min, 1);

    // Full one-minute countdown: RING exactly 240 edges after go.
    btn_go = 1; step(); btn_go = 0;
    chk("cnt_state", state_o,   1);
    chk("cnt_load",  remaining, 60);
    repeat (239) step();
    chk("pre_ring_state",  state_o,   1);
    chk("pre_ring_remain", remaining, 1);
    step();
    chk("ring_state",  state_o,   3);
    chk("ring_start",  start,     1);
    chk("ring_stop",   stop,      0);
    chk("ring_remain", remaining, 0);
    step();
    chk("ring_start_drop", start, 0);
    chk("ring_stop_hold",  stop,  0);

    // Snooze once, ring again after 2 s, second snooze refused.
    btn_go = 1; step(); btn_go = 0;
    chk("snz_state",  state_o,   4);
    chk("snz_remain", remaining, 2);
    chk("snz_stop",   stop,      1);
    repeat (7) step();
    chk("snz_pre_state",  state_o,   4);
    chk("snz_pre_remain", remaining, 1);
    step();
    chk("ring2_state", state_o, 3);
    chk("ring2_start", start,   1);
    step();
    press(2, 1);
    chk("snz_limit_state", state_o, 3);
    chk("snz_limit_start", start,   0);
    btn_stop = 1; step(); btn_stop = 0;
    chk("silence_state", state_o, 0);
    chk("silence_stop",  stop,    1);
    step();

    // Pause after 10 counting cycles, hold 50, resume: 230 more counting cycles.
    btn_go = 1; step(); btn_go = 0;
    repeat (9) step();
    btn_go = 1; step(); btn_go = 0;
    chk("pause_state",  state_o,   2);
    chk("pause_remain", remaining, 58);
    repeat (50) step();
    chk("pause_hold_state",  state_o,   2);
    chk("pause_hold_remain", remaining, 58);
    btn_go = 1; step(); btn_go = 0;
    chk("resume_state", state_o, 1);
    repeat (229) step();
    chk("resume_pre_state",  state_o,   1);
    chk("resume_pre_remain", remaining, 1);
    step();
    chk("resume_ring_state", state_o, 3);
    chk("resume_ring_start", start,   1);
    press(3, 1);
    chk("resume_stop_idle", state_o, 0);

    // up ignored in COUNT; stop+go together cancels.
    btn_go = 1; step(); btn_go = 0; step();
    press(0, 1);
    chk("up_in_count_min",   set_min, 1);
    chk("up_in_count_state", state_o, 1);
    btn_stop = 1; btn_go = 1; step(); btn_stop = 0; btn_go = 0;
    chk("stopgo_state",  state_o,   0);
    chk("stopgo_remain", remaining, 0);
    step();

    // stop on the final tick: IDLE and no start pulse.
    btn_go = 1; step(); btn_go = 0;
    repeat (239) step();
    btn_stop = 1; step(); btn_stop = 0;
    chk("lasttick_state",  state_o,   0);
    chk("lasttick_start",  start,     0);
    chk("lasttick_stop",   stop,      1);
    chk("lasttick_remain", remaining, 0);
    step();
    chk("lasttick_start2", start,   0);
    chk("lasttick_state2", state_o, 0);

    // Async reset mid-count discards the programmed length.
    press(0, 2);
    chk("preset_min", set_min, 3);
    btn_go = 1; step(); btn_go = 0;
    repeat (5) step();
    chk("premid_state", state_o, 1);
    reset = 1'b0;
    #1;
    chk("midrst_state",  state_o,   0);
    chk("midrst_min",    set_min,   1);
    chk("midrst_remain", remaining, 0);
    chk("midrst_start",  start,     0);
    chk("midrst_stop",   stop,      1);
    #3 reset = 1'b1;
    step();
    chk("postrst_state", state_o, 0);

    // Held button produces exactly one event; re-press gives another.
    btn_up = 1;
    repeat (20) step();
    chk("held_up", set_min, 2);
    btn_up = 0; step();
    btn_up = 1; step(); btn_up = 0; step();
    chk("repress_up", set_min, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
